// File: rtl/wb_machine_timer_pkg.sv
// Shared register map, bus/register enums and write-merge helper for the machine timer.
package wb_machine_timer_pkg;

  localparam logic [31:0] TIMER_MTIME_LO    = 32'h00;
  localparam logic [31:0] TIMER_MTIME_HI    = 32'h04;
  localparam logic [31:0] TIMER_MTIMECMP_LO = 32'h08;
  localparam logic [31:0] TIMER_MTIMECMP_HI = 32'h0C;
  localparam logic [31:0] TIMER_CTRL        = 32'h10;

  localparam int unsigned TIMER_CTRL_ENABLE = 0;

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACK,
    BUS_ERR
  } bus_state_e;

  function automatic reg_sel_e decode_reg(input logic [31:0] byte_off);
    reg_sel_e r;
    case (byte_off)
      TIMER_MTIME_LO:    r = REG_MTIME_LO;
      TIMER_MTIME_HI:    r = REG_MTIME_HI;
      TIMER_MTIMECMP_LO: r = REG_MTIMECMP_LO;
      TIMER_MTIMECMP_HI: r = REG_MTIMECMP_HI;
      TIMER_CTRL:        r = REG_CTRL;
      default:           r = REG_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_machine_timer_prescaler.sv
// Divides clk_i by PRESCALE: one-cycle tick every PRESCALE enabled cycles; frozen while disabled.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (enable) count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/wb_machine_timer.sv
// RISC-V machine timer (mtime/mtimecmp) behind a Wishbone classic slave with 1-cycle ack/err.
// Reading MTIME_LO snapshots the upper half so a following MTIME_HI read is coherent.
module wb_machine_timer
  import wb_machine_timer_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        err_o,
  input  logic        timer_interrupt_enable,
  output logic        timer_interrupt
);

  bus_state_e  state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] hi_latch_q, hi_latch_d;
  logic [31:0] dat_q, dat_d;
  logic        enable_q, enable_d;
  logic        pending_q;
  logic        tick;
  logic        req;
  logic [31:0] byte_off;
  reg_sel_e    reg_sel;
  logic        unused_adr;

  // Upper address bits are decoded by the interconnect.
  assign unused_adr = ^adr_i;
  assign byte_off   = 32'(adr_i[ADDR_BITS-1:0]) & ~32'd3;
  assign reg_sel    = decode_reg(byte_off);

  assign req   = cyc_i && stb_i && (state_q == BUS_IDLE);
  assign ack_o = (state_q == BUS_ACK);
  assign err_o = (state_q == BUS_ERR);
  assign dat_o = dat_q;

  assign timer_interrupt = pending_q && timer_interrupt_enable;

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .enable (enable_q),
    .tick   (tick)
  );

  // A software write to either mtime half overrides that cycle's increment entirely.
  always_comb begin
    state_d    = BUS_IDLE;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    enable_d   = enable_q;
    hi_latch_d = hi_latch_q;
    dat_d      = dat_q;
    if (req) begin
      if (reg_sel == REG_NONE) begin
        state_d = BUS_ERR;
        if (!we_i) dat_d = '0;
      end else begin
        state_d = BUS_ACK;
        if (we_i) begin
          case (reg_sel)
            REG_MTIME_LO:    mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], dat_i, sel_i)};
            REG_MTIME_HI:    mtime_d = {merge_lanes(mtime_q[63:32], dat_i, sel_i), mtime_q[31:0]};
            REG_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_lanes(mtimecmp_q[31:0], dat_i, sel_i);
            REG_MTIMECMP_HI: mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], dat_i, sel_i);
            REG_CTRL:        if (sel_i[0]) enable_d = dat_i[TIMER_CTRL_ENABLE];
            default:         ;
          endcase
        end else begin
          case (reg_sel)
            REG_MTIME_LO: begin
              dat_d      = mtime_q[31:0];
              hi_latch_d = mtime_q[63:32];
            end
            REG_MTIME_HI:    dat_d = hi_latch_q;
            REG_MTIMECMP_LO: dat_d = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: dat_d = mtimecmp_q[63:32];
            REG_CTRL: begin
              dat_d = '0;
              dat_d[TIMER_CTRL_ENABLE] = enable_q;
            end
            default:         dat_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= BUS_IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      enable_q   <= 1'b1;
      hi_latch_q <= '0;
      dat_q      <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      enable_q   <= enable_d;
      hi_latch_q <= hi_latch_d;
      dat_q      <= dat_d;
      pending_q  <= (mtime_q >= mtimecmp_q);
    end
  end

endmodule

// File: tb/tb_wb_machine_timer.sv
// Scoreboard bench for wb_machine_timer: two instances (PRESCALE 1 and 4) against a cycle-level reference model.
module tb_wb_machine_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dat_i [2];
  logic [31:0] dat_o [2];
  logic [31:0] adr_i [2];
  logic [3:0]  sel_i [2];
  logic        we_i  [2];
  logic        stb_i [2];
  logic        cyc_i [2];
  logic        ack_o [2];
  logic        err_o [2];
  logic        tie   [2];
  logic        irq   [2];

  always #5 clk = ~clk;

  wb_machine_timer #(.PRESCALE(1), .ADDR_BITS(5)) u_p1 (
    .clk_i(clk), .rst_i(rst), .dat_i(dat_i[0]), .dat_o(dat_o[0]), .adr_i(adr_i[0]),
    .sel_i(sel_i[0]), .we_i(we_i[0]), .stb_i(stb_i[0]), .cyc_i(cyc_i[0]),
    .ack_o(ack_o[0]), .err_o(err_o[0]),
    .timer_interrupt_enable(tie[0]), .timer_interrupt(irq[0])
  );

  wb_machine_timer #(.PRESCALE(4), .ADDR_BITS(5)) u_p4 (
    .clk_i(clk), .rst_i(rst), .dat_i(dat_i[1]), .dat_o(dat_o[1]), .adr_i(adr_i[1]),
    .sel_i(sel_i[1]), .we_i(we_i[1]), .stb_i(stb_i[1]), .cyc_i(cyc_i[1]),
    .ack_o(ack_o[1]), .err_o(err_o[1]),
    .timer_interrupt_enable(tie[1]), .timer_interrupt(irq[1])
  );

  typedef struct {
    int unsigned d;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned ack_cnt [2];
  int unsigned err_cnt [2];

  // Reference state: mtime as a plain 64-bit number, prescaling from a count of enabled cycles.
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2];
  logic [31:0] m_hi    [2];
  bit          m_en    [2];
  bit          m_pend  [2];
  bit          m_busy  [2];
  int unsigned m_e     [2];

  function automatic int unsigned presc(input int unsigned d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int unsigned d = 0; d < 2; d++) begin
      m_mtime[d] = 64'd0;
      m_cmp[d]   = {64{1'b1}};
      m_hi[d]    = 32'd0;
      m_en[d]    = 1'b1;
      m_pend[d]  = 1'b0;
      m_busy[d]  = 1'b0;
      m_e[d]     = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input int unsigned d);
    bit          req, tick, nen;
    logic [4:0]  off;
    logic [31:0] a, nhi;
    logic [63:0] nmt, ncmp;
    exp_t        e;
    req  = cyc_i[d] && stb_i[d] && !m_busy[d];
    tick = 1'b0;
    if (m_en[d]) begin
      m_e[d]++;
      tick = (m_e[d] % presc(d)) == 0;
    end
    nmt  = tick ? m_mtime[d] + 64'd1 : m_mtime[d];
    ncmp = m_cmp[d];
    nhi  = m_hi[d];
    nen  = m_en[d];
    if (req) begin
      a      = adr_i[d];
      off    = a[4:0] & 5'h1C;
      e.d    = d;
      e.rd   = !we_i[d];
      e.err  = (off > 5'h10);
      e.data = 32'd0;
      if (!e.err && e.rd) begin
        case (off)
          5'h00: begin e.data = m_mtime[d][31:0]; nhi = m_mtime[d][63:32]; end
          5'h04: e.data = m_hi[d];
          5'h08: e.data = m_cmp[d][31:0];
          5'h0C: e.data = m_cmp[d][63:32];
          default: e.data = {31'd0, m_en[d]};
        endcase
      end else if (!e.err) begin
        case (off)
          5'h00: nmt = {m_mtime[d][63:32], lanes(m_mtime[d][31:0], dat_i[d], sel_i[d])};
          5'h04: nmt = {lanes(m_mtime[d][63:32], dat_i[d], sel_i[d]), m_mtime[d][31:0]};
          5'h08: ncmp[31:0]  = lanes(m_cmp[d][31:0], dat_i[d], sel_i[d]);
          5'h0C: ncmp[63:32] = lanes(m_cmp[d][63:32], dat_i[d], sel_i[d]);
          default: if (sel_i[d][0]) nen = dat_i[d][0];
        endcase
      end
      exp_q.push_back(e);
    end
    m_pend[d]  = m_mtime[d] >= m_cmp[d];
    m_mtime[d] = nmt;
    m_cmp[d]   = ncmp;
    m_hi[d]    = nhi;
    m_en[d]    = nen;
    m_busy[d]  = req;
  endtask

  task automatic model_loop();
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else for (int unsigned d = 0; d < 2; d++) model_step(d);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int unsigned d = 0; d < 2; d++) begin
        check($sformatf("irq%0d", d), 64'(irq[d]), 64'(m_pend[d] && tie[d]));
        if (ack_o[d] || err_o[d]) begin
          if (ack_o[d]) ack_cnt[d]++;
          if (err_o[d]) err_cnt[d]++;
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_resp%0d", d), 64'({ack_o[d], err_o[d]}), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("resp_dut", 64'(d), 64'(e.d));
            check("ack", 64'(ack_o[d]), 64'(!e.err));
            check("err", 64'(err_o[d]), 64'(e.err));
            if (e.rd) check($sformatf("rdata%0d", d), 64'(dat_o[d]), 64'(e.data));
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input int unsigned d, input bit w, input logic [4:0] off,
                     input logic [31:0] data, input logic [3:0] s);
    logic [31:0] r;
    int unsigned k;
    r        = $urandom();
    adr_i[d] = {r[31:5], off};
    dat_i[d] = data;
    sel_i[d] = s;
    we_i[d]  = w;
    cyc_i[d] = 1'b1;
    stb_i[d] = 1'b1;
    k = 0;
    while (!(ack_o[d] || err_o[d]) && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (!(ack_o[d] || err_o[d])) begin
      n_tests++;
      n_fail++;
      $display("FAIL bus_timeout dut%0d off %0h: no ack/err within 8 cycles", d, off);
    end
    // Strobe stays high across the ack cycle; it must not start a second transfer.
    @(posedge clk);
    #1;
    cyc_i[d] = 1'b0;
    stb_i[d] = 1'b0;
    we_i[d]  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int unsigned d = 0; d < 2; d++) begin
      check($sformatf("%s_ack%0d", tag, d), 64'(ack_o[d]), 64'(0));
      check($sformatf("%s_err%0d", tag, d), 64'(err_o[d]), 64'(0));
      check($sformatf("%s_dat%0d", tag, d), 64'(dat_o[d]), 64'(0));
      check($sformatf("%s_irq%0d", tag, d), 64'(irq[d]), 64'(0));
    end
  endtask

  initial begin
    int unsigned ca, ce, d, gap;
    logic [4:0]  off;
    logic [31:0] data;
    logic [3:0]  s;
    bit          w;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      dat_i[i] = '0; adr_i[i] = '0; sel_i[i] = '0; we_i[i] = 1'b0;
      stb_i[i] = 1'b0; cyc_i[i] = 1'b0; tie[i] = 1'b0;
      ack_cnt[i] = 0; err_cnt[i] = 0;
    end
    fork
      model_loop();
      monitor_loop();
    join_none

    #3;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Free-running count, then a LO/HI pair.
    repeat (10) step();
    bus(0, 0, 5'h00, '0, 4'hF);
    bus(0, 0, 5'h04, '0, 4'hF);
    bus(0, 0, 5'h08, '0, 4'hF);
    bus(0, 0, 5'h10, '0, 4'hF);

    // Compare at 20 with the interrupt unmasked.
    tie[0] = 1'b1;
    bus(0, 1, 5'h0C, 32'd0, 4'hF);
    bus(0, 1, 5'h04, 32'd0, 4'hF);
    bus(0, 1, 5'h00, 32'd0, 4'hF);
    bus(0, 1, 5'h08, 32'd20, 4'hF);
    repeat (25) step();
    tie[0] = 1'b0;
    #1 check("irq_mask_comb", 64'(irq[0]), 64'(0));
    step();
    tie[0] = 1'b1;
    #1 check("irq_unmask_comb", 64'(irq[0]), 64'(1));
    bus(0, 1, 5'h08, 32'hFFFF_FFF0, 4'hF);
    check("irq_clear_2cyc", 64'(irq[0]), 64'(0));

    // Carry from LO into HI, and LO-then-HI coherence around it.
    for (int unsigned k = 0; k < 5; k++) begin
      bus(0, 1, 5'h04, 32'd0, 4'hF);
      bus(0, 1, 5'h00, 32'hFFFF_FFFF - k, 4'hF);
      bus(0, 0, 5'h00, '0, 4'hF);
      bus(0, 0, 5'h04, '0, 4'hF);
    end

    // Byte lanes on MTIMECMP_LO, empty sel, CTRL reserved bits.
    bus(0, 1, 5'h08, 32'h1234_5678, 4'hF);
    bus(0, 1, 5'h08, 32'h00AB_0000, 4'b0100);
    bus(0, 0, 5'h08, '0, 4'hF);
    bus(0, 1, 5'h08, 32'hFFFF_FFFF, 4'h0);
    bus(0, 0, 5'h08, '0, 4'hF);
    bus(0, 1, 5'h10, 32'hFFFF_FFFF, 4'hF);
    bus(0, 0, 5'h10, '0, 4'hF);

    // Unmapped offsets and single ack per held strobe.
    ca = ack_cnt[0];
    ce = err_cnt[0];
    bus(0, 0, 5'h18, '0, 4'hF);
    bus(0, 1, 5'h18, 32'hDEAD_BEEF, 4'hF);
    bus(0, 1, 5'h14, 32'hDEAD_BEEF, 4'hF);
    bus(0, 0, 5'h1C, '0, 4'hF);
    repeat (2) step();
    check("err_no_ack", 64'(ack_cnt[0] - ca), 64'(0));
    check("err_count", 64'(err_cnt[0] - ce), 64'(4));
    ca = ack_cnt[0];
    bus(0, 0, 5'h08, '0, 4'hF);
    repeat (3) step();
    check("single_ack", 64'(ack_cnt[0] - ca), 64'(1));

    // PRESCALE=4: freeze, hold, re-enable.
    bus(1, 0, 5'h00, '0, 4'hF);
    bus(1, 1, 5'h10, 32'd0, 4'hF);
    bus(1, 0, 5'h00, '0, 4'hF);
    repeat (50) step();
    bus(1, 0, 5'h00, '0, 4'hF);
    bus(1, 1, 5'h10, 32'd1, 4'h1);
    for (int unsigned k = 0; k < 6; k++) bus(1, 0, 5'h00, '0, 4'hF);

    // Randomized traffic on both instances.
    for (int unsigned i = 0; i < 300; i++) begin
      d    = $urandom_range(0, 1);
      off  = {3'($urandom_range(0, 7)), 2'b00};
      w    = 1'($urandom_range(0, 1));
      data = $urandom();
      s    = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      if (off == 5'h04 || off == 5'h0C) data = 32'($urandom_range(0, 1));
      if (off == 5'h08 && $urandom_range(0, 1) == 1) data = 32'($urandom_range(0, 3000));
      if (off == 5'h10 && $urandom_range(0, 3) != 0) data = 32'd1;
      if ($urandom_range(0, 7) == 0) tie[d] = ~tie[d];
      bus(d, w, off, data, s);
      gap = $urandom_range(0, 3);
      repeat (gap) step();
    end

    // Reset in the middle of an ack with the interrupt asserted.
    tie[0] = 1'b1;
    bus(0, 1, 5'h10, 32'd1, 4'hF);
    bus(0, 1, 5'h0C, 32'd0, 4'hF);
    bus(0, 1, 5'h08, 32'd0, 4'hF);
    bus(0, 1, 5'h04, 32'd0, 4'hF);
    bus(0, 1, 5'h00, 32'hCAFE_0000, 4'hF);
    adr_i[0] = 32'h0;
    we_i[0]  = 1'b0;
    cyc_i[0] = 1'b1;
    stb_i[0] = 1'b1;
    step();
    check("pre_rst_ack", 64'(ack_o[0]), 64'(1));
    check("pre_rst_irq", 64'(irq[0]), 64'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    cyc_i[0] = 1'b0;
    stb_i[0] = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    bus(0, 0, 5'h08, '0, 4'hF);
    bus(0, 0, 5'h0C, '0, 4'hF);
    bus(0, 0, 5'h10, '0, 4'hF);
    bus(0, 0, 5'h00, '0, 4'hF);
    bus(1, 0, 5'h00, '0, 4'hF);

    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
